// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX controller, the register block and the RX side.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // 115200 baud from a 50 MHz clock (bit period in clocks, minus 1)
  localparam logic [15:0] DEFAULT_DIV = 16'd433;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// TX FIFO read port: first-word-fall-through head data plus a pop strobe.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_do;
  logic                 fifo_re;

  modport master (output fifo_empty, output fifo_do, input fifo_re);
  modport slave  (input fifo_empty, input fifo_do, output fifo_re);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: load the period minus one, tick on the last cycle of the bit.
module uart_baud_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops the TX FIFO and serializes each byte onto tx.
// IDLE wait for byte | START low bit | DATA 8 bits LSB first | PARITY optional | STOP 1-2 high bits
module uart_tx_ctrl #(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  uart_tx_ctrl_if.slave        fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  import uart_pkg::*;

  tx_state_e            state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;

  logic                 tick;
  logic                 last_stop;
  logic                 pop;
  logic                 baud_load;
  logic [DIV_WIDTH-1:0] baud_value;

  assign last_stop  = (state_q == ST_STOP) && tick && (!stop2_q || stop_cnt_q);
  assign pop        = !reset && enable && !fifo.fifo_empty
                      && ((state_q == ST_IDLE) || last_stop);
  assign baud_load  = pop || ((state_q != ST_IDLE) && tick);
  // A new frame runs on the live divisor; later bits use the latched copy.
  assign baud_value = pop ? div : div_q;

  uart_baud_counter #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk   (clk),
    .reset (reset),
    .load  (baud_load),
    .value (baud_value),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_bit_d  = par_bit_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;

    case (state_q)
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      state_d   = ST_START;
      shift_d   = fifo.fifo_do;
      par_bit_d = parity_odd ? ~^fifo.fifo_do : ^fifo.fifo_do;
      div_d     = div;
      par_en_d  = parity_en;
      stop2_d   = stop2;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      par_bit_q  <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_bit_q  <= par_bit_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
    end
  end

  assign fifo.fifo_re = pop;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done      = last_stop && !reset;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model plus a per-cycle scoreboard of the expected tx waveform.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [15:0] div = 16'd3;
  logic        tx, busy, tx_done;

  uart_tx_ctrl_if fifo_if();

  uart_tx_ctrl #(.DIV_WIDTH(16), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div        (div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo       (fifo_if),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  logic [7:0] fifo_q[$];
  exp_t exp_q[$];
  int   re_cyc_q[$];
  int   done_cyc_q[$];
  logic pend_pop = 1'b0;
  logic rst_prev = 1'b0;

  // Expected line waveform, one entry per clock, from the frame format alone.
  function automatic void push_frame(input logic [7:0] d, input logic [15:0] dv,
                                     input logic pe, input logic po, input logic s2);
    logic [11:0] fb;
    int nb;
    exp_t e;
    fb = 12'hFFF;
    fb[0] = 1'b0;
    fb[8:1] = d;
    if (pe) fb[9] = po ? ~^d : ^d;
    nb = 10 + int'(pe) + int'(s2);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= int'(dv); k++) begin
        e.tx = fb[b];
        e.done = (b == nb - 1) && (k == int'(dv));
        exp_q.push_back(e);
      end
    end
  endfunction

  // FIFO model: single driver of the interface inputs, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (pend_pop) begin
      pend_pop = 1'b0;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    fifo_if.fifo_empty = (fifo_q.size() == 0);
    fifo_if.fifo_do = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    logic eb, exp_re;
    cyc++;
    if (reset) begin
      total++;
      if (fifo_if.fifo_re !== 1'b0) $display("FAIL re_in_reset cyc %0d: got %b expected 0", cyc, fifo_if.fifo_re);
      else passed++;
      if (rst_prev) begin
        total++;
        if ({tx, busy, tx_done} !== 3'b100)
          $display("FAIL reset_outputs cyc %0d: tx/busy/done got %b expected 100", cyc, {tx, busy, tx_done});
        else passed++;
      end
      exp_q.delete();
      pend_pop = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        eb = 1'b1;
      end else begin
        e.tx = 1'b1;
        e.done = 1'b0;
        eb = 1'b0;
      end
      exp_re = enable && (fifo_if.fifo_empty === 1'b0) && (exp_q.size() == 0);
      total++;
      if ({tx, busy, tx_done, fifo_if.fifo_re} !== {e.tx, eb, e.done, exp_re})
        $display("FAIL line cyc %0d: tx/busy/done/re got %b expected %b",
                 cyc, {tx, busy, tx_done, fifo_if.fifo_re}, {e.tx, eb, e.done, exp_re});
      else passed++;
      if (fifo_if.fifo_re === 1'b1) begin
        push_frame(fifo_if.fifo_do, div, parity_en, parity_odd, stop2);
        pend_pop = 1'b1;
        re_cyc_q.push_back(cyc);
      end
      if (tx_done === 1'b1) done_cyc_q.push_back(cyc);
    end
    rst_prev = reset;
  end

  task automatic wait_quiet(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (!pend_pop && exp_q.size() == 0 && busy === 1'b0 && (fifo_q.size() == 0 || !enable)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_re(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (re_cyc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++;
    if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else passed++;
    total++;
    if (fifo_if.fifo_re !== 1'b0) $display("FAIL reset_re: got %b expected 0", fifo_if.fifo_re); else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    @(posedge clk); #2;
    re_cyc_q.delete(); done_cyc_q.delete();
    div = 16'd3; parity_en = 1'b0; stop2 = 1'b0; enable = 1'b1;
    fifo_q.push_back(8'h55);
    wait_quiet(200, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL basic_timeout: got %b expected 1", ok); else passed++;
    lat = (re_cyc_q.size() == 1 && done_cyc_q.size() == 1) ? done_cyc_q[0] - re_cyc_q[0] : -1;
    total++;
    if (lat != 40) $display("FAIL basic_frame_len: got %0d expected 40", lat); else passed++;
  endtask

  task automatic test_parity();
    bit ok;
    int lat;
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #2;
      re_cyc_q.delete(); done_cyc_q.delete();
      div = 16'd1; parity_en = 1'b1; parity_odd = p[0]; stop2 = 1'b0; enable = 1'b1;
      fifo_q.push_back(8'h07);
      wait_quiet(200, ok);
      lat = (ok && re_cyc_q.size() == 1 && done_cyc_q.size() == 1) ? done_cyc_q[0] - re_cyc_q[0] : -1;
      total++;
      if (lat != 22) $display("FAIL parity_frame_len odd=%0d: got %0d expected 22", p, lat); else passed++;
    end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int span, gap;
    @(posedge clk); #2;
    re_cyc_q.delete(); done_cyc_q.delete();
    div = 16'd0; parity_en = 1'b0; stop2 = 1'b1; enable = 1'b1;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    wait_quiet(200, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL b2b_timeout: got %b expected 1", ok); else passed++;
    if (re_cyc_q.size() == 2 && done_cyc_q.size() == 2) begin
      span = done_cyc_q[1] - re_cyc_q[0];
      gap = re_cyc_q[1] - done_cyc_q[0];
    end else begin
      span = -1;
      gap = -1;
    end
    total++;
    if (span != 22) $display("FAIL b2b_span: got %0d expected 22", span); else passed++;
    total++;
    if (gap != 0) $display("FAIL b2b_pop_on_last_stop: got %0d expected 0", gap); else passed++;
    stop2 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    @(posedge clk); #2;
    re_cyc_q.delete(); done_cyc_q.delete();
    div = 16'd3; parity_en = 1'b0; stop2 = 1'b0; enable = 1'b1;
    fifo_q.push_back(8'hF0);
    wait_re(1, 50, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL rst_mid_no_pop: got %b expected 1", ok); else passed++;
    repeat (17) @(posedge clk);
    #2 reset = 1'b1;
    fifo_q.push_back(8'h3C);
    @(negedge clk);
    total++;
    if (fifo_if.fifo_re !== 1'b0) $display("FAIL rst_mid_re: got %b expected 0", fifo_if.fifo_re); else passed++;
    @(negedge clk);
    total++;
    if ({tx, busy} !== 2'b10) $display("FAIL rst_mid_tx_busy: got %b expected 10", {tx, busy}); else passed++;
    @(posedge clk); #2 reset = 1'b0;
    wait_quiet(200, ok);
    total++;
    if (ok !== 1'b1 || re_cyc_q.size() != 2 || done_cyc_q.size() != 1)
      $display("FAIL rst_mid_resume: got pops %0d frames %0d expected 2 1", re_cyc_q.size(), done_cyc_q.size());
    else passed++;
  endtask

  task automatic test_enable();
    bit ok;
    @(posedge clk); #2;
    re_cyc_q.delete(); done_cyc_q.delete();
    enable = 1'b0; div = 16'd1; parity_en = 1'b0; stop2 = 1'b0;
    fifo_q.push_back(8'h81);
    repeat (20) @(posedge clk);
    #2;
    total++;
    if (re_cyc_q.size() != 0 || tx !== 1'b1)
      $display("FAIL en_off_pops: got pops %0d tx %b expected 0 1", re_cyc_q.size(), tx);
    else passed++;
    fifo_q.push_back(8'h42);
    enable = 1'b1;
    wait_re(1, 50, ok);
    repeat (4) @(posedge clk);
    #2 enable = 1'b0;
    wait_quiet(200, ok);
    total++;
    if (ok !== 1'b1 || re_cyc_q.size() != 1 || done_cyc_q.size() != 1 || fifo_q.size() != 1)
      $display("FAIL en_drop_mid: got pops %0d frames %0d left %0d expected 1 1 1",
               re_cyc_q.size(), done_cyc_q.size(), fifo_q.size());
    else passed++;
    enable = 1'b1;
    wait_quiet(200, ok);
    total++;
    if (ok !== 1'b1 || re_cyc_q.size() != 2) $display("FAIL en_drain: got pops %0d expected 2", re_cyc_q.size());
    else passed++;
  endtask

  task automatic test_div_change();
    bit ok;
    int l0, l1;
    @(posedge clk); #2;
    re_cyc_q.delete(); done_cyc_q.delete();
    div = 16'd3; parity_en = 1'b0; stop2 = 1'b0; enable = 1'b1;
    fifo_q.push_back(8'h96);
    fifo_q.push_back(8'h69);
    wait_re(1, 50, ok);
    repeat (6) @(posedge clk);
    #2;
    div = 16'd7;
    parity_en = 1'b1;
    wait_quiet(400, ok);
    if (ok && re_cyc_q.size() == 2 && done_cyc_q.size() == 2) begin
      l0 = done_cyc_q[0] - re_cyc_q[0];
      l1 = done_cyc_q[1] - re_cyc_q[1];
    end else begin
      l0 = -1;
      l1 = -1;
    end
    total++;
    if (l0 != 40) $display("FAIL div_chg_first_len: got %0d expected 40", l0); else passed++;
    total++;
    if (l1 != 88) $display("FAIL div_chg_second_len: got %0d expected 88", l1); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable();
    test_div_change();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
